// File: rtl/gray_monitor.sv
// gray_monitor
//   Downstream checker for a W-bit Gray up-counter with a sticky overflow flag.
//   Samples Gray every cycle, converts it to binary, verifies that each change
//   is a legal single-step increment (with Ovf consistent with wrap-around),
//   counts steps and wraps, and latches the first protocol violation.
//
// Ports:
//   Clk        clock, rising edge
//   Reset      synchronous active-high reset (priority over everything)
//   Gray       Gray code from upstream counter
//   Ovf        sticky overflow flag from upstream counter
//   Clear      synchronous soft clear of error, counts and tracking state
//   Bin        registered binary of last sampled Gray (1-cycle latency)
//   Valid      high while tracking (Bin is checked data)
//   StepCount  legal increments since reset/clear/resync, saturating
//   WrapCount  legal wraps (max -> 0), saturating
//   Err        sticky error flag
//   ErrCode    first error cause: 00 none, 01 multi-bit, 10 backward, 11 ovf
module gray_monitor #(
  parameter int unsigned W  = 3,
  parameter int unsigned CW = 8
) (
  input  logic          Clk,
  input  logic          Reset,
  input  logic [W-1:0]  Gray,
  input  logic          Ovf,
  input  logic          Clear,
  output logic [W-1:0]  Bin,
  output logic          Valid,
  output logic [CW-1:0] StepCount,
  output logic [CW-1:0] WrapCount,
  output logic          Err,
  output logic [1:0]    ErrCode
);

  typedef enum logic [1:0] {
    SYNC  = 2'd0,
    TRACK = 2'd1,
    FAULT = 2'd2
  } state_t;

  localparam logic [1:0] CODE_NONE  = 2'b00;
  localparam logic [1:0] CODE_MULTI = 2'b01;
  localparam logic [1:0] CODE_BACK  = 2'b10;
  localparam logic [1:0] CODE_OVF   = 2'b11;

  state_t        state, state_n;
  logic [W-1:0]  prev_gray;
  logic          prev_ovf;
  logic [CW-1:0] step_n, wrap_n;
  logic [1:0]    code_n;

  logic [W-1:0]  nb, pb, d;

  function automatic logic [W-1:0] g2b(input logic [W-1:0] g);
    logic [W-1:0] b;
    b[W-1] = g[W-1];
    for (int unsigned i = 0; i < W - 1; i++) begin
      b[W-2-i] = b[W-1-i] ^ g[W-2-i];
    end
    return b;
  endfunction

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    return (v == '1) ? v : v + CW'(1);
  endfunction

  assign nb = g2b(Gray);
  assign pb = g2b(prev_gray);
  assign d  = Gray ^ prev_gray;

  assign Valid = (state == TRACK);
  assign Err   = (state == FAULT);

  always_comb begin
    state_n = state;
    step_n  = StepCount;
    wrap_n  = WrapCount;
    code_n  = ErrCode;
    if (Clear) begin
      state_n = SYNC;
      step_n  = '0;
      wrap_n  = '0;
      code_n  = CODE_NONE;
    end else begin
      unique case (state)
        SYNC: state_n = TRACK;
        TRACK: begin
          // Rules are checked in priority order; an upstream reset (back to
          // zero with Ovf low) must win over every fault check.
          if (Gray == '0 && !Ovf && (prev_gray != '0 || prev_ovf)) begin
            step_n = '0;
            wrap_n = '0;
          end else if (d == '0) begin
            if (Ovf != prev_ovf) begin
              state_n = FAULT;
              code_n  = CODE_OVF;
            end
          end else if ($countones(d) > 1) begin
            state_n = FAULT;
            code_n  = CODE_MULTI;
          end else if (nb != pb + W'(1)) begin
            state_n = FAULT;
            code_n  = CODE_BACK;
          end else if (pb != '1) begin
            if (Ovf != prev_ovf) begin
              state_n = FAULT;
              code_n  = CODE_OVF;
            end else begin
              step_n = sat_inc(StepCount);
            end
          end else begin
            if (!Ovf) begin
              state_n = FAULT;
              code_n  = CODE_OVF;
            end else begin
              step_n = sat_inc(StepCount);
              wrap_n = sat_inc(WrapCount);
            end
          end
        end
        FAULT: state_n = FAULT;
        default: state_n = SYNC;
      endcase
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state     <= SYNC;
      Bin       <= '0;
      prev_gray <= '0;
      prev_ovf  <= 1'b0;
      StepCount <= '0;
      WrapCount <= '0;
      ErrCode   <= CODE_NONE;
    end else begin
      state     <= state_n;
      Bin       <= nb;
      prev_gray <= Gray;
      prev_ovf  <= Ovf;
      StepCount <= step_n;
      WrapCount <= wrap_n;
      ErrCode   <= code_n;
    end
  end

endmodule

// File: tb/tb_gray_monitor.sv
module tb_gray_monitor;

  logic       Clk = 1'b0;
  logic       Reset = 1'b1;
  logic [2:0] Gray = 3'b000;
  logic       Ovf = 1'b0;
  logic       Clear = 1'b0;

  logic [2:0] Bin, Bin2;
  logic       Valid, Valid2, Err, Err2;
  logic [7:0] StepCount, WrapCount;
  logic [1:0] StepCount2, WrapCount2;
  logic [1:0] ErrCode, ErrCode2;

  int errors = 0;
  int checks = 0;

  always #5 Clk = ~Clk;

  gray_monitor #(.W(3), .CW(8)) dut (
    .Clk(Clk), .Reset(Reset), .Gray(Gray), .Ovf(Ovf), .Clear(Clear),
    .Bin(Bin), .Valid(Valid), .StepCount(StepCount), .WrapCount(WrapCount),
    .Err(Err), .ErrCode(ErrCode)
  );

  gray_monitor #(.W(3), .CW(2)) dut2 (
    .Clk(Clk), .Reset(Reset), .Gray(Gray), .Ovf(Ovf), .Clear(Clear),
    .Bin(Bin2), .Valid(Valid2), .StepCount(StepCount2), .WrapCount(WrapCount2),
    .Err(Err2), .ErrCode(ErrCode2)
  );

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Drive one sample, clock it in, and settle just after the edge.
  task automatic step(input logic [2:0] g, input logic o,
                      input logic clr, input logic rst);
    Gray  = g;
    Ovf   = o;
    Clear = clr;
    Reset = rst;
    @(posedge Clk);
    #1;
  endtask

  // Full status check of the CW=8 instance.
  task automatic st(input string tag, input int bin, input int vld,
                    input int sc, input int wc, input int er, input int ec);
    chk({tag, ".bin"},  int'(Bin), bin);
    chk({tag, ".vld"},  int'(Valid), vld);
    chk({tag, ".step"}, int'(StepCount), sc);
    chk({tag, ".wrap"}, int'(WrapCount), wc);
    chk({tag, ".err"},  int'(Err), er);
    chk({tag, ".code"}, int'(ErrCode), ec);
  endtask

  logic [2:0] gseq [8];

  initial begin
    gseq[0] = 3'b000; gseq[1] = 3'b001; gseq[2] = 3'b011; gseq[3] = 3'b010;
    gseq[4] = 3'b110; gseq[5] = 3'b111; gseq[6] = 3'b101; gseq[7] = 3'b100;

    // Reset state
    step(3'b000, 1'b0, 1'b0, 1'b1);
    st("rst", 0, 0, 0, 0, 0, 0);

    // First sample after reset is the SYNC baseline
    step(3'b000, 1'b0, 1'b0, 1'b0);
    st("sync", 0, 1, 0, 0, 0, 0);

    // Count up through 1..7 with Ovf low
    for (int i = 1; i < 8; i++) begin
      step(gseq[i], 1'b0, 1'b0, 1'b0);
      chk($sformatf("up%0d.bin", i), int'(Bin), i);
      chk($sformatf("up%0d.step", i), int'(StepCount), i);
    end
    st("up7", 7, 1, 7, 0, 0, 0);

    // Legal wrap with Ovf high
    step(3'b000, 1'b1, 1'b0, 1'b0);
    st("wrap1", 0, 1, 8, 1, 0, 0);

    // Second lap with Ovf held high
    for (int i = 1; i < 8; i++) step(gseq[i], 1'b1, 1'b0, 1'b0);
    st("lap2", 7, 1, 15, 1, 0, 0);
    step(3'b000, 1'b1, 1'b0, 1'b0);
    st("wrap2", 0, 1, 16, 2, 0, 0);

    // Resync: from 011 back to 000 with Ovf low
    step(3'b001, 1'b1, 1'b0, 1'b0);
    step(3'b011, 1'b1, 1'b0, 1'b0);
    chk("pre_resync.step", int'(StepCount), 18);
    step(3'b000, 1'b0, 1'b0, 1'b0);
    st("resync", 0, 1, 0, 0, 0, 0);
    step(3'b001, 1'b0, 1'b0, 1'b0);
    st("resync_inc", 1, 1, 1, 0, 0, 0);

    // Multi-bit change 001 -> 010
    step(3'b000, 1'b0, 1'b0, 1'b1);
    step(3'b000, 1'b0, 1'b0, 1'b0);
    step(3'b001, 1'b0, 1'b0, 1'b0);
    step(3'b010, 1'b0, 1'b0, 1'b0);
    st("multi", 3, 0, 1, 0, 1, 1);
    step(3'b110, 1'b0, 1'b0, 1'b0);
    st("multi_hold", 4, 0, 1, 0, 1, 1);

    // Backward step 011 -> 001
    step(3'b000, 1'b0, 1'b0, 1'b1);
    step(3'b000, 1'b0, 1'b0, 1'b0);
    step(3'b001, 1'b0, 1'b0, 1'b0);
    step(3'b011, 1'b0, 1'b0, 1'b0);
    step(3'b001, 1'b0, 1'b0, 1'b0);
    st("back", 1, 0, 2, 0, 1, 2);

    // Ovf rises while Gray holds 010
    step(3'b000, 1'b0, 1'b0, 1'b1);
    step(3'b000, 1'b0, 1'b0, 1'b0);
    step(3'b001, 1'b0, 1'b0, 1'b0);
    step(3'b011, 1'b0, 1'b0, 1'b0);
    step(3'b010, 1'b0, 1'b0, 1'b0);
    step(3'b010, 1'b1, 1'b0, 1'b0);
    st("ovf_hold", 3, 0, 3, 0, 1, 3);

    // Clear out of FAULT, then SYNC -> TRACK and a legal increment
    step(3'b010, 1'b1, 1'b1, 1'b0);
    st("clr", 3, 0, 0, 0, 0, 0);
    step(3'b010, 1'b1, 1'b0, 1'b0);
    st("clr_sync", 3, 1, 0, 0, 0, 0);
    step(3'b110, 1'b1, 1'b0, 1'b0);
    st("clr_inc", 4, 1, 1, 0, 0, 0);

    // Clear together with an illegal jump 110 -> 001
    step(3'b001, 1'b1, 1'b1, 1'b0);
    st("clr_jump", 1, 0, 0, 0, 0, 0);

    // Reset mid-sequence
    step(3'b011, 1'b0, 1'b0, 1'b0);
    step(3'b010, 1'b0, 1'b0, 1'b0);
    chk("mid.step", int'(StepCount), 1);
    step(3'b110, 1'b0, 1'b0, 1'b1);
    st("mid_rst", 0, 0, 0, 0, 0, 0);

    // Increment with Ovf changing outside a wrap
    step(3'b000, 1'b0, 1'b0, 1'b0);
    step(3'b001, 1'b1, 1'b0, 1'b0);
    st("inc_ovf", 1, 0, 0, 0, 1, 3);

    // Five increments: CW=8 counts 5, CW=2 saturates at 3
    step(3'b000, 1'b0, 1'b0, 1'b1);
    step(3'b000, 1'b0, 1'b0, 1'b0);
    for (int i = 1; i < 6; i++) step(gseq[i], 1'b0, 1'b0, 1'b0);
    chk("sat.step8", int'(StepCount), 5);
    chk("sat.step2", int'(StepCount2), 3);
    chk("sat.err2", int'(Err2), 0);
    chk("sat.bin2", int'(Bin2), 5);
    step(gseq[6], 1'b0, 1'b0, 1'b0);
    chk("sat.hold2", int'(StepCount2), 3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
